// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory access encodings
// and the load/store unit state machine type.
package cpu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] RESULT_SEL_MEM = 2'b01;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } lsu_state_t;

   // Byte-sized access (signed or unsigned)
   function automatic logic f3_is_byte(input logic [2:0] f3);
      return (f3 == F3_B) || (f3 == F3_BU);
   endfunction

   // Half-sized access (signed or unsigned)
   function automatic logic f3_is_half(input logic [2:0] f3);
      return (f3 == F3_H) || (f3 == F3_HU);
   endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Load lane extraction and sign/zero extension.
// Anything not B/H/BU/HU passes the word through.
module lsu_load_extend
   import cpu_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  a_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   // Pick the addressed lane, then extend by access type
   always_comb begin
      byte_v = rdata_i[7:0];
      unique case (a_i)
         2'd1:    byte_v = rdata_i[15:8];
         2'd2:    byte_v = rdata_i[23:16];
         2'd3:    byte_v = rdata_i[31:24];
         default: byte_v = rdata_i[7:0];
      endcase
      half_v = a_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      data_o = rdata_i;
      case (funct3_i)
         F3_B:    data_o = {{24{byte_v[7]}}, byte_v};
         F3_BU:   data_o = {24'h0, byte_v};
         F3_H:    data_o = {{16{half_v[15]}}, half_v};
         F3_HU:   data_o = {16'h0, half_v};
         default: data_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: req/ack data bus master
// with lane steering, load extension and stall control.
module mem_lsu
   import cpu_pkg::*;
#(
   parameter int DATA_WIDTH      = 32,
   parameter int DATA_ADDR_WIDTH = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [DATA_ADDR_WIDTH-1:0] alu_res_EX_MEM_o,
   input  logic [DATA_WIDTH-1:0]      write_data_EX_MEM_o,
   input  logic                       mem_write_EX_MEM_o,
   input  logic [1:0]                 result_sel_EX_MEM_o,
   input  logic [2:0]                 funct3_EX_MEM_o,
   output logic                       dmem_req,
   output logic                       dmem_we,
   output logic [DATA_ADDR_WIDTH-1:0] dmem_addr,
   output logic [3:0]                 dmem_be,
   output logic [DATA_WIDTH-1:0]      dmem_wdata,
   input  logic                       dmem_ack,
   input  logic [DATA_WIDTH-1:0]      dmem_rdata,
   output logic [DATA_WIDTH-1:0]      load_data_MEM,
   output logic                       mem_stall,
   output logic                       misalign_err
);

   lsu_state_t state_q, state_d;

   logic                  access;
   logic                  size_b;
   logic                  size_h;
   logic                  size_w;
   logic                  misalign;
   logic                  go;
   logic [1:0]            a;
   logic [3:0]            be_d;
   logic [DATA_WIDTH-1:0] wdata_d;
   logic [DATA_WIDTH-1:0] ext_data;

   logic                       req_q;
   logic                       we_q;
   logic [DATA_ADDR_WIDTH-1:0] addr_q;
   logic [3:0]                 be_q;
   logic [DATA_WIDTH-1:0]      wdata_q;
   logic [DATA_WIDTH-1:0]      ld_q;
   logic [1:0]                 a_q;
   logic [2:0]                 f3_q;

   // Decode the access, check alignment, steer store lanes
   always_comb begin
      access = mem_write_EX_MEM_o |
               (result_sel_EX_MEM_o == RESULT_SEL_MEM);
      a        = alu_res_EX_MEM_o[1:0];
      size_b   = f3_is_byte(funct3_EX_MEM_o);
      size_h   = f3_is_half(funct3_EX_MEM_o);
      size_w   = ~size_b & ~size_h;
      misalign = access & ((size_h & a[0]) |
                           (size_w & (a != 2'b00)));
      go       = access & ~misalign;
      be_d     = 4'b1111;
      wdata_d  = '0;
      if (mem_write_EX_MEM_o) begin
         unique case (1'b1)
            size_b: begin
               be_d    = 4'b0001 << a;
               wdata_d = {4{write_data_EX_MEM_o[7:0]}};
            end
            size_h: begin
               be_d    = 4'b0011 << a;
               wdata_d = {2{write_data_EX_MEM_o[15:0]}};
            end
            default: begin
               be_d    = 4'b1111;
               wdata_d = write_data_EX_MEM_o;
            end
         endcase
      end
   end

   // Next state and stall; DONE releases the pipe once
   always_comb begin
      state_d   = state_q;
      mem_stall = 1'b0;
      case (state_q)
         IDLE: begin
            if (go) begin
               mem_stall = 1'b1;
               state_d   = BUSY;
            end
         end
         BUSY: begin
            mem_stall = 1'b1;
            if (dmem_ack) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Bus request registers and load result capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         be_q    <= 4'b0000;
         wdata_q <= '0;
         ld_q    <= '0;
         a_q     <= 2'b00;
         f3_q    <= 3'b000;
      end else if (state_q == IDLE && go) begin
         req_q   <= 1'b1;
         we_q    <= mem_write_EX_MEM_o;
         addr_q  <= {alu_res_EX_MEM_o[DATA_ADDR_WIDTH-1:2], 2'b00};
         be_q    <= be_d;
         wdata_q <= wdata_d;
         a_q     <= a;
         f3_q    <= funct3_EX_MEM_o;
      end else if (state_q == BUSY && dmem_ack) begin
         req_q <= 1'b0;
         if (!we_q) ld_q <= ext_data;
      end
   end

   lsu_load_extend u_ext (
      .rdata_i  (dmem_rdata),
      .a_i      (a_q),
      .funct3_i (f3_q),
      .data_o   (ext_data)
   );

   assign dmem_req      = req_q;
   assign dmem_we       = we_q;
   assign dmem_addr     = addr_q;
   assign dmem_be       = be_q;
   assign dmem_wdata    = wdata_q;
   assign load_data_MEM = ld_q;
   assign misalign_err  = misalign;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu and its load extender.
// Expected values are hand-computed constants.
module tb_mem_lsu;
   import cpu_pkg::*;

   logic        clk;
   logic        rst_n;
   logic [31:0] alu;
   logic [31:0] wd_in;
   logic        mw;
   logic [1:0]  rs;
   logic [2:0]  f3;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic        ack;
   logic [31:0] rdata;
   logic [31:0] ld;
   logic        stall;
   logic        mis;

   logic [31:0] x_rd;
   logic [1:0]  x_a;
   logic [2:0]  x_f3;
   logic [31:0] x_out;

   int tests;
   int fails;

   mem_lsu dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .alu_res_EX_MEM_o    (alu),
      .write_data_EX_MEM_o (wd_in),
      .mem_write_EX_MEM_o  (mw),
      .result_sel_EX_MEM_o (rs),
      .funct3_EX_MEM_o     (f3),
      .dmem_req            (req),
      .dmem_we             (we),
      .dmem_addr           (addr),
      .dmem_be             (be),
      .dmem_wdata          (wdata),
      .dmem_ack            (ack),
      .dmem_rdata          (rdata),
      .load_data_MEM       (ld),
      .mem_stall           (stall),
      .misalign_err        (mis)
   );

   lsu_load_extend u_ref_ext (
      .rdata_i  (x_rd),
      .a_i      (x_a),
      .funct3_i (x_f3),
      .data_o   (x_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_idle();
      alu = 32'h0; wd_in = 32'h0; mw = 1'b0;
      rs = 2'b00; f3 = 3'b000; ack = 1'b0; rdata = 32'h0;
   endtask

   // Drive one access from IDLE; ends 1ns into DONE
   task automatic do_access(
      input  logic [31:0] a_in,
      input  logic [31:0] w_in,
      input  logic        m_in,
      input  logic [1:0]  r_in,
      input  logic [2:0]  f_in,
      input  int          waits,
      input  logic [31:0] rd_in,
      output int          stalls,
      output logic        c_we,
      output logic [3:0]  c_be,
      output logic [31:0] c_addr,
      output logic [31:0] c_wdata,
      output logic        stable,
      output logic        tmo
   );
      int busy;
      alu = a_in; wd_in = w_in; mw = m_in; rs = r_in; f3 = f_in;
      ack = 1'b0; rdata = 32'h0;
      stalls = 0; busy = 0; stable = 1'b1; tmo = 1'b1;
      c_we = 1'b0; c_be = 4'h0; c_addr = 32'h0; c_wdata = 32'h0;
      for (int cyc = 0; cyc < 64; cyc++) begin
         #1;
         if (!stall) begin
            tmo = 1'b0;
            break;
         end
         stalls++;
         if (req) begin
            if (busy == 0) begin
               c_we = we; c_be = be; c_addr = addr; c_wdata = wdata;
            end else if (we !== c_we || be !== c_be ||
                         addr !== c_addr || wdata !== c_wdata) begin
               stable = 1'b0;
            end
            if (busy == waits) begin
               ack = 1'b1;
               rdata = rd_in;
            end
            busy++;
         end
         @(negedge clk);
         ack = 1'b0;
         rdata = 32'h0;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      set_idle();
      repeat (2) @(negedge clk);
      tests++;
      if ({req, we, be} !== 6'b0) begin
         fails++;
         $display("FAIL reset_ctl: got %b want 000000", {req, we, be});
      end
      tests++;
      if (addr !== 32'h0 || wdata !== 32'h0 || ld !== 32'h0) begin
         fails++;
         $display("FAIL reset_data: got %h/%h/%h want 0", addr, wdata, ld);
      end
      rst_n = 1'b1;
      @(negedge clk);
      tests++;
      if ({stall, mis, req} !== 3'b000) begin
         fails++;
         $display("FAIL reset_idle: got %b want 000", {stall, mis, req});
      end
   endtask

   task automatic test_extend();
      logic [2:0]  vf [10];
      logic [1:0]  va [10];
      logic [31:0] vr [10];
      logic [31:0] ve [10];
      vf = '{F3_B, F3_BU, F3_B, F3_H, F3_HU,
             F3_H, F3_W, 3'b011, F3_B, F3_HU};
      va = '{2'd2, 2'd2, 2'd0, 2'd2, 2'd2,
             2'd0, 2'd0, 2'd0, 2'd3, 2'd0};
      vr = '{32'h00800000, 32'h00800000, 32'h0000007F,
             32'h80010000, 32'h80010000, 32'h00007FFF,
             32'h12345678, 32'hCAFEBABE, 32'hAB000000,
             32'h1234F00D};
      ve = '{32'hFFFFFF80, 32'h00000080, 32'h0000007F,
             32'hFFFF8001, 32'h00008001, 32'h00007FFF,
             32'h12345678, 32'hCAFEBABE, 32'hFFFFFFAB,
             32'h0000F00D};
      for (int i = 0; i < 10; i++) begin
         x_f3 = vf[i]; x_a = va[i]; x_rd = vr[i];
         #1;
         tests++;
         if (x_out !== ve[i]) begin
            fails++;
            $display("FAIL extend[%0d]: got %h want %h", i, x_out, ve[i]);
         end
      end
   endtask

   task automatic test_sw();
      int n; logic cwe, st, to; logic [3:0] cbe;
      logic [31:0] cad, cwd;
      @(negedge clk);
      do_access(32'h100, 32'hDEADBEEF, 1'b1, 2'b00, F3_W, 0, 32'h0,
                n, cwe, cbe, cad, cwd, st, to);
      tests++;
      if (to !== 1'b0 || n != 2) begin
         fails++;
         $display("FAIL sw_stall: got %0d cycles (tmo %b) want 2", n, to);
      end
      tests++;
      if ({cwe, cbe} !== 5'b11111) begin
         fails++;
         $display("FAIL sw_we_be: got %b want 11111", {cwe, cbe});
      end
      tests++;
      if (cad !== 32'h100 || cwd !== 32'hDEADBEEF) begin
         fails++;
         $display("FAIL sw_addr_data: got %h/%h want 100/deadbeef", cad, cwd);
      end
      tests++;
      if (req !== 1'b0) begin
         fails++;
         $display("FAIL sw_done_req: got %b want 0", req);
      end
      set_idle();
      @(negedge clk);
      #1;
      tests++;
      if ({stall, req} !== 2'b00) begin
         fails++;
         $display("FAIL sw_no_reissue: got %b want 00", {stall, req});
      end
   endtask

   task automatic test_store_lanes();
      int n; logic cwe, st, to; logic [3:0] cbe;
      logic [31:0] cad, cwd;
      @(negedge clk);
      do_access(32'h103, 32'h000000A5, 1'b1, 2'b00, F3_B, 0, 32'h0,
                n, cwe, cbe, cad, cwd, st, to);
      tests++;
      if (to !== 1'b0 || cbe !== 4'b1000 || cad !== 32'h100 ||
          cwd !== 32'hA5A5A5A5) begin
         fails++;
         $display("FAIL sb_lane: got be %b addr %h data %h want 1000/100/a5a5a5a5",
                  cbe, cad, cwd);
      end
      set_idle();
      @(negedge clk);
      do_access(32'h104, 32'h11223344, 1'b1, 2'b00, 3'b111, 1, 32'h0,
                n, cwe, cbe, cad, cwd, st, to);
      tests++;
      if (to !== 1'b0 || n != 3 || cbe !== 4'b1111 ||
          cad !== 32'h104 || cwd !== 32'h11223344 || st !== 1'b1) begin
         fails++;
         $display("FAIL f3_111_as_w: got n %0d be %b addr %h data %h stable %b",
                  n, cbe, cad, cwd, st);
      end
      set_idle();
      @(negedge clk);
   endtask

   task automatic test_load_ext();
      int n; logic cwe, st, to; logic [3:0] cbe;
      logic [31:0] cad, cwd;
      do_access(32'h102, 32'h0, 1'b0, RESULT_SEL_MEM, F3_B, 3,
                32'h00800000, n, cwe, cbe, cad, cwd, st, to);
      tests++;
      if (to !== 1'b0 || n != 5) begin
         fails++;
         $display("FAIL lb_stall: got %0d (tmo %b) want 5", n, to);
      end
      tests++;
      if ({cwe, cbe} !== 5'b01111 || cad !== 32'h100 || st !== 1'b1) begin
         fails++;
         $display("FAIL lb_bus: got we/be %b addr %h stable %b want 01111/100/1",
                  {cwe, cbe}, cad, st);
      end
      tests++;
      if (ld !== 32'hFFFFFF80) begin
         fails++;
         $display("FAIL lb_data: got %h want ffffff80", ld);
      end
      set_idle();
      @(negedge clk);
      do_access(32'h102, 32'h0, 1'b0, RESULT_SEL_MEM, F3_BU, 3,
                32'h00800000, n, cwe, cbe, cad, cwd, st, to);
      tests++;
      if (to !== 1'b0 || n != 5 || ld !== 32'h00000080) begin
         fails++;
         $display("FAIL lbu_data: got %h n %0d want 00000080 n 5", ld, n);
      end
      set_idle();
      @(negedge clk);
   endtask

   task automatic test_misalign();
      logic bad;
      alu = 32'h101; mw = 1'b0; rs = RESULT_SEL_MEM; f3 = F3_H;
      #1;
      tests++;
      if ({mis, stall} !== 2'b10) begin
         fails++;
         $display("FAIL lh_mis_flag: got mis/stall %b want 10", {mis, stall});
      end
      bad = 1'b0;
      repeat (3) begin
         @(negedge clk);
         #1;
         if (req !== 1'b0 || stall !== 1'b0) bad = 1'b1;
      end
      tests++;
      if (bad !== 1'b0 || ld !== 32'h00000080) begin
         fails++;
         $display("FAIL lh_mis_quiet: got bad %b ld %h want 0/00000080", bad, ld);
      end
      alu = 32'h202; f3 = F3_W; mw = 1'b1; rs = 2'b00;
      #1;
      tests++;
      if ({mis, stall} !== 2'b10) begin
         fails++;
         $display("FAIL sw_mis_flag: got mis/stall %b want 10", {mis, stall});
      end
      alu = 32'h202; f3 = F3_HU; mw = 1'b0; rs = RESULT_SEL_MEM;
      #1;
      tests++;
      if ({mis, stall} !== 2'b01) begin
         fails++;
         $display("FAIL lhu_aligned: got mis/stall %b want 01", {mis, stall});
      end
      set_idle();
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int n; logic cwe, st, to; logic [3:0] cbe;
      logic [31:0] cad, cwd;
      do_access(32'h200, 32'h0, 1'b0, RESULT_SEL_MEM, F3_W, 0,
                32'h12345678, n, cwe, cbe, cad, cwd, st, to);
      tests++;
      if (to !== 1'b0 || n != 2 || ld !== 32'h12345678) begin
         fails++;
         $display("FAIL lw_data: got %h n %0d want 12345678 n 2", ld, n);
      end
      alu = 32'h202; wd_in = 32'h0000BEEF; mw = 1'b1;
      rs = 2'b00; f3 = F3_H;
      #1;
      tests++;
      if ({stall, req} !== 2'b00) begin
         fails++;
         $display("FAIL b2b_done_gap: got stall/req %b want 00", {stall, req});
      end
      @(negedge clk);
      do_access(32'h202, 32'h0000BEEF, 1'b1, 2'b00, F3_H, 0, 32'h0,
                n, cwe, cbe, cad, cwd, st, to);
      tests++;
      if (to !== 1'b0 || n != 2 || cbe !== 4'b1100 ||
          cwd !== 32'hBEEFBEEF || cad !== 32'h200 || cwe !== 1'b1) begin
         fails++;
         $display("FAIL sh_lane: got n %0d be %b data %h addr %h we %b",
                  n, cbe, cwd, cad, cwe);
      end
      tests++;
      if (ld !== 32'h12345678) begin
         fails++;
         $display("FAIL ld_hold: got %h want 12345678", ld);
      end
      set_idle();
      @(negedge clk);
   endtask

   task automatic test_reset_busy();
      alu = 32'h300; mw = 1'b0; rs = RESULT_SEL_MEM; f3 = F3_W;
      @(negedge clk);
      #1;
      tests++;
      if (req !== 1'b1) begin
         fails++;
         $display("FAIL rb_busy: got req %b want 1", req);
      end
      rst_n = 1'b0;
      #1;
      tests++;
      if (req !== 1'b0 || addr !== 32'h0 || be !== 4'h0 ||
          ld !== 32'h0 || dut.state_q !== IDLE) begin
         fails++;
         $display("FAIL rb_async: got req %b addr %h be %b ld %h", req, addr, be, ld);
      end
      set_idle();
      @(negedge clk);
      rst_n = 1'b1;
      ack = 1'b1; rdata = 32'hFFFFFFFF;
      @(negedge clk);
      ack = 1'b0; rdata = 32'h0;
      #1;
      tests++;
      if ({req, stall} !== 2'b00 || ld !== 32'h0 ||
          dut.state_q !== IDLE) begin
         fails++;
         $display("FAIL rb_stray_ack: got req/stall %b ld %h want 00/0",
                  {req, stall}, ld);
      end
      @(negedge clk);
   endtask

   initial begin
      tests = 0;
      fails = 0;
      x_rd = 32'h0; x_a = 2'b00; x_f3 = 3'b000;
      test_reset();
      test_extend();
      test_sw();
      test_store_lanes();
      test_load_ext();
      test_misalign();
      test_back_to_back();
      test_reset_busy();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
